// File: rtl/mem_trace_buffer_if.sv
// Memory handshake bundle between the core and its memory. The core side
// drives every field; the trace buffer only observes them.
interface mem_trace_buffer_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_ready, mem_addr, mem_wstrb, mem_wdata, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_ready, mem_addr, mem_wstrb, mem_wdata, mem_rdata
   );
endinterface

// File: rtl/mem_trace_buffer.sv
// Trace buffer for completed memory transactions. Hits inside the address
// window are stored in a circular buffer of DEPTH entries and popped later
// with rd_en. When full, capture either stops (drop counted) or overwrites
// the oldest entry (overflow flagged), selected per hit by mode_wrap.
module mem_trace_buffer #(
   parameter int unsigned DEPTH   = 16,
   parameter logic [31:0] ADDR_LO = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI = 32'hFFFF_FFFF,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   mem_trace_buffer_if.slave         mem,
   input  logic                      arm,
   input  logic                      stop,
   input  logic                      clr,
   input  logic                      mode_wrap,
   input  logic                      rd_en,
   output logic [64:0]               rd_data,
   output logic                      rd_valid,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      capturing,
   output logic                      overflow,
   output logic [CNT_W-1:0]          drop_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   localparam logic [PTR_W:0]   FULL_C   = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DROP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // Inclusive unsigned window test on the full 32-bit address.
   function automatic logic in_window(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (a >= lo) && (a <= hi);
   endfunction

   state_t           state_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [64:0]      rd_data_r;
   logic             rd_valid_r;
   logic             capturing_r;
   logic             overflow_r;
   logic [CNT_W-1:0] drop_cnt_r;
   logic [64:0]      buf_r [DEPTH];

   logic             hit_s;
   logic             pop_s;
   logic             full_s;
   logic             blocked_s;
   logic             wr_s;
   logic             ovw_s;
   logic             drop_s;
   logic             is_write_s;
   logic [64:0]      entry_s;

   // Classify this cycle's hit and pop; clr beats arm/stop, which beat capture.
   always_comb begin
      hit_s      = 1'b0;
      pop_s      = 1'b0;
      is_write_s = 1'b0;
      entry_s    = 65'd0;
      hit_s      = (state_r == ST_CAPTURE) && mem.mem_valid && mem.mem_ready
                   && in_window(mem.mem_addr, ADDR_LO, ADDR_HI)
                   && !clr && !arm && !stop;
      pop_s      = rd_en && (count_r != '0) && !clr;
      full_s     = (count_r == FULL_C);
      // A simultaneous pop frees a slot, so a full buffer takes the hit normally.
      blocked_s  = hit_s && full_s && !pop_s;
      ovw_s      = blocked_s && mode_wrap;
      drop_s     = blocked_s && !mode_wrap;
      wr_s       = hit_s && !drop_s;
      is_write_s = (mem.mem_wstrb != 4'b0000);
      if (is_write_s) begin
         entry_s = {1'b1, mem.mem_addr, mem.mem_wdata};
      end else begin
         entry_s = {1'b0, mem.mem_addr, mem.mem_rdata};
      end
   end

   // Entry storage; contents need no reset since only counted slots are read.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         buf_r[wr_ptr_r] <= entry_s;
      end
   end

   // Capture FSM, pointers, occupancy, flags and the registered read port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         capturing_r <= 1'b0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         overflow_r  <= 1'b0;
         drop_cnt_r  <= '0;
         rd_valid_r  <= 1'b0;
         rd_data_r   <= 65'd0;
      end else if (clr) begin
         state_r     <= ST_IDLE;
         capturing_r <= 1'b0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         overflow_r  <= 1'b0;
         drop_cnt_r  <= '0;
         rd_valid_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (arm) begin
                  state_r     <= ST_CAPTURE;
                  capturing_r <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (stop || drop_s) begin
                  state_r     <= ST_DONE;
                  capturing_r <= 1'b0;
               end
            end
            ST_DONE: begin
               if (arm) begin
                  state_r     <= ST_CAPTURE;
                  capturing_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               capturing_r <= 1'b0;
            end
         endcase

         rd_valid_r <= pop_s;
         if (pop_s) begin
            rd_data_r <= buf_r[rd_ptr_r];
         end

         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end

         // Overwrite discards the oldest entry, so the read side advances too.
         if (pop_s || ovw_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end

         case ({wr_s && !ovw_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase

         if (ovw_s) begin
            overflow_r <= 1'b1;
         end

         if (drop_s && (drop_cnt_r != DROP_MAX)) begin
            drop_cnt_r <= drop_cnt_r + DROP_ONE;
         end
      end
   end

   assign rd_data   = rd_data_r;
   assign rd_valid  = rd_valid_r;
   assign count     = count_r;
   assign capturing = capturing_r;
   assign overflow  = overflow_r;
   assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_mem_trace_buffer.sv
// Bench for mem_trace_buffer. Instance A: DEPTH=4, full address window.
// Instance W: DEPTH=16, window 0x100..0x1FF. Popped entries are checked by
// a scoreboard monitor; status outputs are checked directly by the driver.
module tb_mem_trace_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   mem_trace_buffer_if a_if ();
   mem_trace_buffer_if w_if ();

   logic        a_arm, a_stop, a_clr, a_wrap, a_rd;
   logic [64:0] a_rd_data;
   logic        a_rd_valid, a_cap, a_ovf;
   logic [2:0]  a_count;
   logic [15:0] a_drop;

   logic        w_arm, w_stop, w_clr, w_wrap, w_rd;
   logic [64:0] w_rd_data;
   logic        w_rd_valid, w_cap, w_ovf;
   logic [4:0]  w_count;
   logic [15:0] w_drop;

   mem_trace_buffer #(.DEPTH(4), .ADDR_LO(32'h0000_0000), .ADDR_HI(32'hFFFF_FFFF), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .mem(a_if),
      .arm(a_arm), .stop(a_stop), .clr(a_clr), .mode_wrap(a_wrap), .rd_en(a_rd),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count),
      .capturing(a_cap), .overflow(a_ovf), .drop_cnt(a_drop)
   );

   mem_trace_buffer #(.DEPTH(16), .ADDR_LO(32'h0000_0100), .ADDR_HI(32'h0000_01FF), .CNT_W(16)) u_w (
      .clk(clk), .rst(rst), .mem(w_if),
      .arm(w_arm), .stop(w_stop), .clr(w_clr), .mode_wrap(w_wrap), .rd_en(w_rd),
      .rd_data(w_rd_data), .rd_valid(w_rd_valid), .count(w_count),
      .capturing(w_cap), .overflow(w_ovf), .drop_cnt(w_drop)
   );

   int tests = 0;
   int fails = 0;
   logic [64:0] qa [$];
   logic [64:0] qw [$];

   function automatic logic [64:0] ent(input logic w, input logic [31:0] a, input logic [31:0] d);
      return {w, a, d};
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every rd_valid must match the oldest expected entry,
   // and an expected entry with no rd_valid one cycle after rd_en is missing.
   always @(negedge clk) begin : mon
      logic [64:0] e;
      if (a_rd_valid) begin
         tests++;
         if (qa.size() == 0) begin
            fails++;
            $display("FAIL a_unexpected_pop: got %h expected no entry", a_rd_data);
         end else begin
            e = qa.pop_front();
            if (a_rd_data !== e) begin
               fails++;
               $display("FAIL a_pop_data: got %h expected %h", a_rd_data, e);
            end
         end
      end else if (qa.size() != 0) begin
         tests++;
         fails++;
         e = qa.pop_front();
         $display("FAIL a_pop_missing: got rd_valid 0 expected entry %h", e);
      end
      if (w_rd_valid) begin
         tests++;
         if (qw.size() == 0) begin
            fails++;
            $display("FAIL w_unexpected_pop: got %h expected no entry", w_rd_data);
         end else begin
            e = qw.pop_front();
            if (w_rd_data !== e) begin
               fails++;
               $display("FAIL w_pop_data: got %h expected %h", w_rd_data, e);
            end
         end
      end else if (qw.size() != 0) begin
         tests++;
         fails++;
         e = qw.pop_front();
         $display("FAIL w_pop_missing: got rd_valid 0 expected entry %h", e);
      end
   end

   // All tasks start and end at a falling edge.
   task automatic hit(input bit s, input logic [31:0] a, input logic [3:0] ws,
                      input logic [31:0] wd, input logic [31:0] rdv);
      if (s) begin
         w_if.mem_valid = 1'b1; w_if.mem_ready = 1'b1; w_if.mem_addr = a;
         w_if.mem_wstrb = ws;   w_if.mem_wdata = wd;   w_if.mem_rdata = rdv;
      end else begin
         a_if.mem_valid = 1'b1; a_if.mem_ready = 1'b1; a_if.mem_addr = a;
         a_if.mem_wstrb = ws;   a_if.mem_wdata = wd;   a_if.mem_rdata = rdv;
      end
      @(negedge clk);
      a_if.mem_valid = 1'b0;
      w_if.mem_valid = 1'b0;
   endtask

   task automatic pop(input bit s, input logic [64:0] e, input bit want);
      if (s) w_rd = 1'b1; else a_rd = 1'b1;
      @(posedge clk);
      if (want) begin
         if (s) qw.push_back(e); else qa.push_back(e);
      end
      @(negedge clk);
      a_rd = 1'b0;
      w_rd = 1'b0;
   endtask

   task automatic pulse_a(input int which);
      if (which == 0) a_arm = 1'b1; else a_clr = 1'b1;
      @(negedge clk);
      a_arm = 1'b0;
      a_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      a_arm = 1'b0; a_stop = 1'b0; a_clr = 1'b0; a_wrap = 1'b0; a_rd = 1'b0;
      w_arm = 1'b0; w_stop = 1'b0; w_clr = 1'b0; w_wrap = 1'b0; w_rd = 1'b0;
      a_if.mem_valid = 1'b0; a_if.mem_ready = 1'b0; a_if.mem_addr = 32'h0;
      a_if.mem_wstrb = 4'h0; a_if.mem_wdata = 32'h0; a_if.mem_rdata = 32'h0;
      w_if.mem_valid = 1'b0; w_if.mem_ready = 1'b0; w_if.mem_addr = 32'h0;
      w_if.mem_wstrb = 4'h0; w_if.mem_wdata = 32'h0; w_if.mem_rdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_count", 65'(a_count), 65'd0);
      chk("reset_flags", 65'({a_cap, a_ovf, a_rd_valid}), 65'd0);
      chk("reset_drop", 65'(a_drop), 65'd0);
      chk("reset_rd_data", a_rd_data, 65'd0);
      rst = 1'b1;
      @(negedge clk);

      // Three instruction fetches, popped back to back.
      pulse_a(0);
      chk("arm_capturing", 65'(a_cap), 65'd1);
      hit(1'b0, 32'h0, 4'h0, 32'hFFFF_FFFF, 32'h13);
      chk("first_hit_count", 65'(a_count), 65'd1);
      hit(1'b0, 32'h4, 4'h0, 32'hFFFF_FFFF, 32'h93);
      hit(1'b0, 32'h8, 4'h0, 32'hFFFF_FFFF, 32'h6F);
      chk("fetch_count", 65'(a_count), 65'd3);
      pop(1'b0, ent(1'b0, 32'h0, 32'h13), 1'b1);
      pop(1'b0, ent(1'b0, 32'h4, 32'h93), 1'b1);
      pop(1'b0, ent(1'b0, 32'h8, 32'h6F), 1'b1);
      chk("drained_count", 65'(a_count), 65'd0);
      pop(1'b0, 65'd0, 1'b0);
      chk("empty_pop_valid", 65'(a_rd_valid), 65'd0);
      chk("empty_pop_count", 65'(a_count), 65'd0);

      // Address window 0x100..0x1FF on the second instance.
      w_arm = 1'b1;
      @(negedge clk);
      w_arm = 1'b0;
      hit(1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h55);
      hit(1'b1, 32'h0000_0200, 4'h0, 32'h0, 32'h1);
      hit(1'b1, 32'h0000_00FF, 4'h0, 32'h0, 32'h2);
      hit(1'b1, 32'h0000_01FF, 4'h0, 32'h0, 32'h77);
      chk("window_count", 65'(w_count), 65'd2);
      pop(1'b1, ent(1'b1, 32'h100, 32'hDEAD_BEEF), 1'b1);
      pop(1'b1, ent(1'b0, 32'h1FF, 32'h77), 1'b1);
      chk("window_drained", 65'(w_count), 65'd0);

      // Stop-on-full: fifth hit dropped, sixth arrives in DONE and is ignored.
      pulse_a(1);
      chk("clr_state", 65'({a_cap, a_count}), 65'd0);
      pulse_a(0);
      a_wrap = 1'b0;
      for (int i = 0; i < 6; i++) hit(1'b0, 32'h10 + 32'(i), 4'h0, 32'h0, 32'hA0 + 32'(i));
      chk("stop_full_count", 65'(a_count), 65'd4);
      chk("stop_full_done", 65'(a_cap), 65'd0);
      chk("stop_full_drop", 65'(a_drop), 65'd1);
      chk("stop_full_ovf", 65'(a_ovf), 65'd0);
      for (int i = 0; i < 4; i++) pop(1'b0, ent(1'b0, 32'h10 + 32'(i), 32'hA0 + 32'(i)), 1'b1);

      // Wrap mode: addresses 0..5, the two oldest are overwritten.
      pulse_a(1);
      chk("clr_drop", 65'(a_drop), 65'd0);
      pulse_a(0);
      a_wrap = 1'b1;
      for (int i = 0; i < 6; i++) hit(1'b0, 32'(i), 4'h0, 32'h0, 32'h100 + 32'(i));
      chk("wrap_count", 65'(a_count), 65'd4);
      chk("wrap_ovf", 65'(a_ovf), 65'd1);
      chk("wrap_capturing", 65'(a_cap), 65'd1);
      for (int i = 2; i < 6; i++) pop(1'b0, ent(1'b0, 32'(i), 32'h100 + 32'(i)), 1'b1);

      // Full buffer with simultaneous hit and pop in stop mode.
      pulse_a(1);
      chk("clr_ovf", 65'(a_ovf), 65'd0);
      pulse_a(0);
      a_wrap = 1'b0;
      for (int i = 0; i < 4; i++) hit(1'b0, 32'h20 + 32'(i), 4'h1, 32'hB0 + 32'(i), 32'h0);
      chk("full_count", 65'(a_count), 65'd4);
      a_rd = 1'b1;
      a_if.mem_valid = 1'b1; a_if.mem_ready = 1'b1; a_if.mem_addr = 32'h24;
      a_if.mem_wstrb = 4'h1; a_if.mem_wdata = 32'hB4; a_if.mem_rdata = 32'h0;
      @(posedge clk);
      qa.push_back(ent(1'b1, 32'h20, 32'hB0));
      @(negedge clk);
      a_rd = 1'b0;
      a_if.mem_valid = 1'b0;
      chk("hitpop_count", 65'(a_count), 65'd4);
      chk("hitpop_ovf", 65'(a_ovf), 65'd0);
      chk("hitpop_drop", 65'(a_drop), 65'd0);
      chk("hitpop_capturing", 65'(a_cap), 65'd1);
      for (int i = 1; i < 5; i++) pop(1'b0, ent(1'b1, 32'h20 + 32'(i), 32'hB0 + 32'(i)), 1'b1);

      // Hit together with stop, then with arm: neither is captured.
      a_stop = 1'b1;
      hit(1'b0, 32'h30, 4'h0, 32'h0, 32'h1);
      a_stop = 1'b0;
      chk("stop_hit_count", 65'(a_count), 65'd0);
      chk("stop_hit_done", 65'(a_cap), 65'd0);
      a_arm = 1'b1;
      hit(1'b0, 32'h31, 4'h0, 32'h0, 32'h2);
      a_arm = 1'b0;
      chk("arm_hit_count", 65'(a_count), 65'd0);
      chk("rearm_capturing", 65'(a_cap), 65'd1);

      // Asynchronous reset in the middle of a capture and a pop.
      for (int i = 0; i < 3; i++) hit(1'b0, 32'h40 + 32'(i), 4'h0, 32'h0, 32'hC0 + 32'(i));
      chk("pre_rst_count", 65'(a_count), 65'd3);
      a_rd = 1'b1;
      a_if.mem_valid = 1'b1; a_if.mem_ready = 1'b1; a_if.mem_addr = 32'h50;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count", 65'(a_count), 65'd0);
      chk("async_rst_flags", 65'({a_cap, a_ovf, a_rd_valid}), 65'd0);
      chk("async_rst_rd_data", a_rd_data, 65'd0);
      chk("async_rst_drop", 65'(a_drop), 65'd0);
      @(negedge clk);
      a_rd = 1'b0;
      a_if.mem_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      pop(1'b0, 65'd0, 1'b0);
      chk("post_rst_pop_valid", 65'(a_rd_valid), 65'd0);
      chk("post_rst_capturing", 65'(a_cap), 65'd0);

      @(negedge clk);
      chk("scoreboard_empty", 65'(qa.size() + qw.size()), 65'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_trace_buffer.md
# mem_trace_buffer

Synthesizable trace buffer that captures completed CPU memory transactions (`mem_valid && mem_ready`) into a parametrised circular buffer, with an address-window filter and stop-on-full or wrap capture modes. It sits beside the core in `top` on the memory handshake and lets the bench, or a debug UART, pop captured entries after the run instead of relying on simulation-only `$display` tracing.

## Interface
- `DEPTH`, 16: entry count; must be a power of two and at least 2.
- `ADDR_LO`, 32'h0000_0000: inclusive lower bound of the capture window.
- `ADDR_HI`, 32'hFFFF_FFFF: inclusive upper bound of the capture window.
- `CNT_W`, 16: width of the drop counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_valid`, `mem_ready` in 1 each: core memory handshake, monitored only.
- `mem_addr` in 32, `mem_wstrb` in 4, `mem_wdata` in 32, `mem_rdata` in 32: transaction fields.
- `arm` in 1: pulse; starts capture.
- `stop` in 1: pulse; ends capture.
- `clr` in 1: pulse; empties the buffer and clears the flags.
- `mode_wrap` in 1: 0 = stop when full; 1 = overwrite the oldest entry. Sampled on every capture.
- `rd_en` in 1: pops the oldest entry.
- `rd_data` out 65: popped entry, `{is_write, addr[31:0], data[31:0]}`.
- `rd_valid` out 1: `rd_data` valid this cycle.
- `count` out log2(DEPTH)+1: number of entries held.
- `capturing` out 1: state is CAPTURE.
- `overflow` out 1: sticky; at least one entry was overwritten in wrap mode.
- `drop_cnt` out CNT_W: saturating count of hits dropped in stop mode.

## Operation
- States: IDLE, CAPTURE, DONE.
  - IDLE to CAPTURE on `arm`.
  - CAPTURE to DONE on `stop`, or on a hit when full and `mode_wrap`=0.
  - DONE to CAPTURE on `arm`. Existing contents are kept.
  - `clr` from any state: go to IDLE, set pointers and `count` to 0, clear `overflow` and `drop_cnt`. `clr` has priority over `arm` and `stop`, which take priority over capture.
- Hit: state CAPTURE and `mem_valid && mem_ready` and `ADDR_LO <= mem_addr <= ADDR_HI`. The comparison is unsigned, full 32 bits.
- Entry fields:
  - `is_write` = (`mem_wstrb` != 0).
  - `data` = `mem_wdata` for writes, `mem_rdata` for reads.
- Hit when not full: write at `wr_ptr`, increment `wr_ptr`, `count`+1.
- Hit when full, `mode_wrap`=1: overwrite the oldest entry, advance both pointers, keep `count`=DEPTH, set `overflow`.
- Hit when full, `mode_wrap`=0: no write, `drop_cnt`+1 (saturates at all-ones), go to DONE.
  - A hit arriving in DONE is ignored and does not increment `drop_cnt`.
- Pop: `rd_en` with `count`!=0 reads at `rd_ptr`, increments `rd_ptr`, `count`-1. `rd_en` with `count`=0 is ignored.
- Pop allowed in any state.
- Simultaneous hit and pop: both take effect, `count` unchanged.
  - When full, the pop frees a slot, so the hit is written with no overwrite, no drop and no `overflow` in either mode.
- Pointers wrap modulo DEPTH with no special case.

## Timing
- Reset values:
  - state IDLE; pointers, `count`, `drop_cnt` = 0.
  - `overflow`, `capturing`, `rd_valid` = 0; `rd_data` = 0.
- Capture latency: a hit at edge N is reflected in `count` after edge N. It can be popped from cycle N+1.
- Read latency: `rd_en` high at edge N gives `rd_data`/`rd_valid` after edge N, for exactly one cycle. `rd_data` holds its value when `rd_valid` is 0.
- Back-to-back `rd_en` yields one entry per cycle.
- `capturing` is registered and follows the state. A hit in the same cycle as `arm` is not captured. A hit in the same cycle as `stop` is not captured.
- Asserting `rst` mid-transaction or mid-pop clears everything immediately, without waiting for a clock edge.

## Test plan
- Reset, `arm`, then 3 fetches at 0x0, 0x4, 0x8 with rdata 0x13, 0x93, 0x6F → `count`=3. Three pops → entries {0,0x0,0x13}, {0,0x4,0x93}, {0,0x8,0x6F}, each with `rd_valid` high one cycle after its `rd_en`.
- Write to 0x100 with `mem_wstrb`=4'b1111 and wdata 0xDEADBEEF, window 0x100–0x1FF; also a read at 0x200 → only one entry, {1,0x100,0xDEADBEEF}.
- DEPTH=4, `mode_wrap`=0, 6 hits → `count`=4, state DONE, `drop_cnt`=1, first 4 entries retained.
- DEPTH=4, `mode_wrap`=1, 6 hits with addresses 0..5 → `count`=4, `overflow`=1, pops return addresses 2, 3, 4, 5.
- Full buffer, hit and `rd_en` in the same cycle → `count` stays 4, no overwrite, `overflow` stays 0, new entry last.
- `rst` low mid-capture with `count`=3 → all outputs 0 immediately. `rd_en` after release gives `rd_valid`=0.
